// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the RV32M multi-cycle multiply/divide block:
//   - ALUoperation encodings for the eight M-extension ops (1000..1111)
//   - FSM state enum used by muldiv_sequencer
//   - RISC-V special-case result constants
//   - a small helper that forms a two's-complement magnitude
package muldiv_pkg;

  localparam logic [3:0] OP_MUL    = 4'b1000;
  localparam logic [3:0] OP_MULH   = 4'b1001;
  localparam logic [3:0] OP_MULHSU = 4'b1010;
  localparam logic [3:0] OP_MULHU  = 4'b1011;
  localparam logic [3:0] OP_DIV    = 4'b1100;
  localparam logic [3:0] OP_DIVU   = 4'b1101;
  localparam logic [3:0] OP_REM    = 4'b1110;
  localparam logic [3:0] OP_REMU   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;
  localparam logic [31:0] INT_MIN   = 32'h80000000;

  // Absolute value of a 32-bit operand when it is to be treated as negative.
  // INT_MIN maps onto itself, which reads correctly as the unsigned 2^31.
  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic neg);
    return neg ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core
// One combinational iteration of the shared multiply/divide datapath.
// The 64-bit accumulator is split as {high, low}:
//   multiply: high = partial product, low = remaining multiplier bits
//   divide:   high = partial remainder, low = dividend bits / quotient bits
// Ports:
//   acc      - current accumulator
//   operand  - multiplicand (multiply) or divisor (divide), both unsigned
//   div_mode - 1 selects the restoring-divide step, 0 the shift-add step
//   next_acc - accumulator after this iteration
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              div_mode,
  output logic [2*XLEN-1:0] next_acc
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted_rem;
  logic            fits;
  logic [XLEN-1:0] diff;

  // The shifted remainder needs XLEN+1 bits for the compare, but whenever the
  // divisor fits the difference is below the divisor, so XLEN bits of the
  // subtraction are enough for the restored value.
  always_comb begin
    sum         = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
    shifted_rem = acc[2*XLEN-1:XLEN-1];
    fits        = (shifted_rem >= {1'b0, operand});
    diff        = acc[2*XLEN-2:XLEN-1] - operand;
    next_acc    = '0;
    if (div_mode) begin
      if (fits) next_acc = {diff, acc[XLEN-2:0], 1'b1};
      else      next_acc = {acc[2*XLEN-2:0], 1'b0};
    end else if (acc[0]) begin
      next_acc = {sum, acc[XLEN-1:1]};
    end else begin
      next_acc = {1'b0, acc[2*XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle RV32M multiply/divide unit for the execute stage. Accepts one
// operation through a valid/ready handshake, iterates 32 times in CALC, applies
// sign correction in FIX and holds the result in DONE until acknowledged.
// Ports:
//   clk, rst     - clock (rising edge) and asynchronous active-high reset
//   in_valid_i   - operation request; in_ready_o is high only in IDLE
//   op_i         - ALUoperation code (1000..1111 legal, op_i[3]=0 illegal)
//   a_i, b_i     - rs1 / rs2 operands
//   flush_i      - pipeline redirect; aborts anything in flight
//   out_valid_o  - result_o / illegal_o are valid, held until out_ready_i
//   out_ready_i  - consumer accepts the result (only looked at in DONE)
//   result_o     - operation result
//   illegal_o    - result belongs to a non-M opcode (result is 0)
//   busy_o       - operation accepted and not yet consumed
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam int CW = $clog2(ITER);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   operand;
  logic [3:0]        op_q;
  logic              sign_q;
  logic              special_q;
  logic              illegal_q;

  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              sign_in;
  logic              special_in;
  logic              illegal_in;
  logic [XLEN-1:0]   special_res;

  logic [2*XLEN-1:0] next_acc;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   remd;
  logic [XLEN-1:0]   fix_result;

  // Request decode: operand signedness per op, the result sign, and the
  // RISC-V corner cases whose answer is known without iterating.
  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    case (op_i)
      OP_MULH, OP_DIV, OP_REM: begin
        a_neg = a_i[XLEN-1];
        b_neg = b_i[XLEN-1];
      end
      OP_MULHSU: a_neg = a_i[XLEN-1];
      default: ;
    endcase
    a_mag   = magnitude(a_i, a_neg);
    b_mag   = magnitude(b_i, b_neg);
    sign_in = (op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);

    special_in  = 1'b0;
    illegal_in  = 1'b0;
    special_res = '0;
    if (!op_i[3]) begin
      special_in = 1'b1;
      illegal_in = 1'b1;
    end else if (op_i[2]) begin
      if (b_i == '0) begin
        special_in  = 1'b1;
        special_res = op_i[1] ? a_i : DIV0_QUOT;
      end else if (op_i == OP_DIV && a_i == INT_MIN && b_i == '1) begin
        special_in  = 1'b1;
        special_res = INT_MIN;
      end else if (op_i == OP_REM && a_i == INT_MIN && b_i == '1) begin
        special_in  = 1'b1;
        special_res = '0;
      end
    end
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .acc      (acc),
    .operand  (operand),
    .div_mode (op_q[2]),
    .next_acc (next_acc)
  );

  // Sign correction and result selection. Special cases carry their final
  // answer in the low accumulator half and bypass the correction.
  always_comb begin
    prod       = sign_q ? (~acc + 64'd1) : acc;
    quot       = sign_q ? (~acc[XLEN-1:0] + 32'd1) : acc[XLEN-1:0];
    remd       = sign_q ? (~acc[2*XLEN-1:XLEN] + 32'd1) : acc[2*XLEN-1:XLEN];
    fix_result = acc[XLEN-1:0];
    if (!special_q) begin
      case (op_q)
        OP_MUL:                       fix_result = prod[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              fix_result = quot;
        OP_REM, OP_REMU:              fix_result = remd;
        default: ;
      endcase
    end
  end

  // Control FSM with registered handshake outputs. flush_i outranks every
  // state, including a request arriving in IDLE during the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      operand     <= '0;
      op_q        <= '0;
      sign_q      <= 1'b0;
      special_q   <= 1'b0;
      illegal_q   <= 1'b0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      illegal_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else if (flush_i) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            op_q       <= op_i;
            operand    <= b_mag;
            acc        <= {{XLEN{1'b0}}, (special_in ? special_res : a_mag)};
            sign_q     <= special_in ? 1'b0 : sign_in;
            special_q  <= special_in;
            illegal_q  <= illegal_in;
            cnt        <= '0;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
            state      <= special_in ? FIX : CALC;
          end
        end
        CALC: begin
          acc <= next_acc;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ITER - 1)) state <= FIX;
        end
        FIX: begin
          result_o    <= fix_result;
          illegal_o   <= illegal_q;
          out_valid_o <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer: directed RV32M vectors, randomized
// operations against an arithmetic reference model, result hold in DONE,
// flush, asynchronous reset mid-operation and illegal opcodes.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic        illegal_o;
  logic        busy_o;

  int checks;
  int errors;

  muldiv_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .illegal_o   (illegal_o),
    .busy_o      (busy_o)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RV32M semantics straight from 64-bit arithmetic.
  // Latency counts clock edges from the accepting edge to the first cycle
  // in which out_valid_o is seen high.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] res,
                                output logic ill, output int lat);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ill = 1'b0;
    lat = 34;
    res = '0;
    case (op)
      4'b1000: begin p = 64'(ua * ub); res = p[31:0];  end
      4'b1001: begin p = 64'(sa * sb); res = p[63:32]; end
      4'b1010: begin p = 64'(sa * ub); res = p[63:32]; end
      4'b1011: begin p = 64'(ua * ub); res = p[63:32]; end
      4'b1100: begin
        if (b == 0) begin res = 32'hFFFFFFFF; lat = 2; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin res = a; lat = 2; end
        else begin p = 64'(sa / sb); res = p[31:0]; end
      end
      4'b1101: begin
        if (b == 0) begin res = 32'hFFFFFFFF; lat = 2; end
        else res = a / b;
      end
      4'b1110: begin
        if (b == 0) begin res = a; lat = 2; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin res = 0; lat = 2; end
        else begin p = 64'(sa % sb); res = p[31:0]; end
      end
      4'b1111: begin
        if (b == 0) begin res = a; lat = 2; end
        else res = a % b;
      end
      default: begin res = 0; ill = 1'b1; lat = 2; end
    endcase
  endfunction

  // Operand generator biased toward the interesting corner values.
  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h00000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Drive one request starting at the current negedge, wait (bounded) for
  // out_valid_o, capture the result and acknowledge it. Leaves the DUT in
  // IDLE at a negedge. A timeout returns lat=100, which no check accepts.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, output logic [31:0] res,
                               output logic ill, output int lat);
    op_i       = op;
    a_i        = a;
    b_i        = b;
    in_valid_i = 1'b1;
    lat        = 0;
    do begin
      @(negedge clk);
      in_valid_i = 1'b0;
      lat++;
    end while (!out_valid_o && lat < 100);
    res = result_o;
    ill = illegal_o;
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
  endtask

  // Reset values right after releasing reset.
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready_o, out_valid_o, result_o, illegal_o, busy_o} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b res=%h ill=%b busy=%b, expected rdy=1 vld=0 res=0 ill=0 busy=0",
               in_ready_o, out_valid_o, result_o, illegal_o, busy_o);
    end
  endtask

  // Directed vectors with hand-computed answers and latencies.
  task automatic test_directed();
    logic [3:0]  ops [12] = '{4'b1000, 4'b1001, 4'b1011, 4'b1100, 4'b1110, 4'b1101,
                              4'b1111, 4'b1101, 4'b1110, 4'b1100, 4'b1110, 4'b1010};
    logic [31:0] as  [12] = '{32'd7, 32'd7, 32'd7, 32'hFFFFFFEC, 32'hFFFFFFEC, 32'd100,
                              32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bs  [12] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd6, 32'd6, 32'd7,
                              32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2};
    logic [31:0] exp [12] = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'h00000006, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd14,
                              32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF};
    int          lats[12] = '{34, 34, 34, 34, 34, 34, 34, 2, 2, 2, 2, 34};
    logic [31:0] res;
    logic        ill;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(ops[i], as[i], bs[i], res, ill, lat);
      checks++;
      if (res !== exp[i] || ill !== 1'b0) begin
        errors++;
        $display("[TB] FAIL directed_result[%0d] op=%b: got %h ill=%b, expected %h ill=0", i, ops[i], res, ill, exp[i]);
      end
      checks++;
      if (lat != lats[i]) begin
        errors++;
        $display("[TB] FAIL directed_latency[%0d] op=%b: got %0d, expected %0d", i, ops[i], lat, lats[i]);
      end
      checks++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL directed_release[%0d]: got vld=%b rdy=%b, expected vld=0 rdy=1", i, out_valid_o, in_ready_o);
      end
    end
  endtask

  // Randomized operations (mostly legal, some illegal) against the model.
  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b, res, exp_res;
    logic        ill, exp_ill;
    int          lat, exp_lat;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
      a  = pick_operand();
      b  = pick_operand();
      model(op, a, b, exp_res, exp_ill, exp_lat);
      applyStimulus(op, a, b, res, ill, lat);
      checks++;
      if (res !== exp_res || ill !== exp_ill || lat != exp_lat) begin
        errors++;
        $display("[TB] FAIL random[%0d] op=%b a=%h b=%h: got res=%h ill=%b lat=%0d, expected res=%h ill=%b lat=%0d",
                 i, op, a, b, res, ill, lat, exp_res, exp_ill, exp_lat);
      end
    end
  endtask

  // Result held in DONE while out_ready_i stays low, new requests ignored,
  // then a back-to-back request in the first IDLE cycle.
  task automatic test_back_to_back();
    logic [31:0] res;
    logic        ill;
    int          lat;
    op_i = 4'b1101; a_i = 32'd1000; b_i = 32'd7; in_valid_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid_i = 1'b0;
      lat++;
    end while (!out_valid_o && lat < 100);
    checks++;
    if (lat != 34) begin
      errors++;
      $display("[TB] FAIL hold_latency: got %0d, expected 34", lat);
    end
    for (int i = 0; i < 10; i++) begin
      op_i = 4'b1000; a_i = 32'd1; b_i = 32'd1; in_valid_i = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_valid_o, result_o, busy_o, in_ready_o} !== {1'b1, 32'd142, 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL hold_cycle[%0d]: got vld=%b res=%h busy=%b rdy=%b, expected vld=1 res=0000008e busy=1 rdy=0",
                 i, out_valid_o, result_o, busy_o, in_ready_o);
      end
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    checks++;
    if ({out_valid_o, in_ready_o, busy_o} !== {1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL hold_release: got vld=%b rdy=%b busy=%b, expected vld=0 rdy=1 busy=0",
               out_valid_o, in_ready_o, busy_o);
    end
    applyStimulus(4'b1000, 32'd3, 32'd5, res, ill, lat);
    checks++;
    if (res !== 32'd15 || lat != 34) begin
      errors++;
      $display("[TB] FAIL back_to_back: got res=%h lat=%0d, expected res=0000000f lat=34", res, lat);
    end
  endtask

  // Flush on CALC cycle 15, flush racing a request in IDLE, then a fresh op.
  task automatic test_flush();
    logic [31:0] res;
    logic        ill;
    int          lat;
    logic        saw_valid;
    op_i = 4'b1000; a_i = 32'h00012345; b_i = 32'h00000777; in_valid_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (14) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checks++;
    if ({in_ready_o, busy_o, out_valid_o} !== {1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL flush_idle: got rdy=%b busy=%b vld=%b, expected rdy=1 busy=0 vld=0",
               in_ready_o, busy_o, out_valid_o);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      saw_valid |= out_valid_o;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_no_result: got out_valid seen=%b, expected 0", saw_valid);
    end
    op_i = 4'b1000; a_i = 32'd9; b_i = 32'd9; in_valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0; flush_i = 1'b0;
    checks++;
    if ({in_ready_o, busy_o} !== {1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL flush_blocks_accept: got rdy=%b busy=%b, expected rdy=1 busy=0", in_ready_o, busy_o);
    end
    applyStimulus(4'b1000, 32'd3, 32'd4, res, ill, lat);
    checks++;
    if (res !== 32'd12 || lat != 34) begin
      errors++;
      $display("[TB] FAIL flush_recovery: got res=%h lat=%0d, expected res=0000000c lat=34", res, lat);
    end
  endtask

  // Asynchronous reset between edges mid-CALC, then an illegal opcode.
  task automatic test_async_reset();
    logic [31:0] res;
    logic        ill;
    int          lat;
    op_i = 4'b1100; a_i = $urandom(); b_i = 32'd3; in_valid_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready_o, out_valid_o, result_o, illegal_o, busy_o} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset: got rdy=%b vld=%b res=%h ill=%b busy=%b, expected rdy=1 vld=0 res=0 ill=0 busy=0",
               in_ready_o, out_valid_o, result_o, illegal_o, busy_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b0010, $urandom(), $urandom(), res, ill, lat);
    checks++;
    if (res !== 32'd0 || ill !== 1'b1 || lat != 2) begin
      errors++;
      $display("[TB] FAIL illegal_op: got res=%h ill=%b lat=%0d, expected res=0 ill=1 lat=2", res, ill, lat);
    end
  endtask

  // Scenario sequence and the single summary line.
  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    op_i        = '0;
    a_i         = '0;
    b_i         = '0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and datapath for the RV32M operations that the single-cycle ALU currently approximates (ALUoperation codes 4'b1000–4'b1111).
- Accepts one operation at a time through a valid/ready handshake and runs a 32-iteration shift-add multiply or restoring divide.
- Applies sign correction and the RISC-V special cases, then presents the result to the execute stage until it is acknowledged.
- The execute stage stalls on busy_o while an operation is in flight.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration count; must equal XLEN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid_i  input  1  operation request
- in_ready_o  output  1  block can accept a request (IDLE only)
- op_i  input  4  ALUoperation encoding: 1000 mul, 1001 mulh, 1010 mulhsu, 1011 mulhu, 1100 div, 1101 divu, 1110 rem, 1111 remu
- a_i  input  32  rs1 operand
- b_i  input  32  rs2 operand
- flush_i  input  1  abort the in-flight operation (pipeline redirect)
- out_valid_o  output  1  result available
- out_ready_i  input  1  consumer accepts the result
- result_o  output  32  operation result
- illegal_o  output  1  qualifies result: op_i[3] was 0
- busy_o  output  1  in_valid accepted and result not yet consumed

Behaviour:
- Reset (async, any state): state=IDLE. in_ready_o=1; out_valid_o=0; result_o=0; illegal_o=0; busy_o=0. All internal registers are cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready_o=1.
  - When in_valid_i is high, a_i/b_i/op_i are latched, and operand magnitudes are formed per op signedness (mulh: both signed; mulhsu: a signed, b unsigned; div/rem: both signed; others unsigned).
  - Result sign flag is latched: for mul*, sign(a) XOR sign(b); for rem, sign(a); for div, sign(a) XOR sign(b).
  - Next state is CALC, except for the special cases below.
- Special cases go directly to FIX, with a precomputed result:
  - op_i[3]=0: result 0, illegal=1.
  - div/divu with b=0: quotient 32'hFFFFFFFF.
  - rem/remu with b=0: result a.
  - div with a=32'h80000000, b=32'hFFFFFFFF: result 32'h80000000.
  - rem with the same operands: result 0.
- CALC:
  - Iteration counter counts 0..ITER-1; one iteration per cycle.
  - Multiply: 64-bit accumulator; add the multiplicand when the LSB of the multiplier is 1, then shift right.
  - Divide: restoring; shift the remainder left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - After iteration ITER-1, go to FIX.
- FIX:
  - Two's-complement negate the 64-bit product / quotient / remainder if the sign flag is set.
  - Select: mul takes the low 32 bits; mulh/mulhsu/mulhu take the high 32 bits; div/divu take the quotient; rem/remu take the remainder.
  - Register into result_o, then go to DONE.
- DONE:
  - out_valid_o=1; result_o and illegal_o are held stable.
  - When out_ready_i is high, go to IDLE, with out_valid_o low on the next cycle.
- Latency:
  - Normal ops: accept at edge T0; CALC on cycles 1–32; FIX on cycle 33; out_valid_o on cycle 34.
  - Special cases: FIX on cycle 1; out_valid_o on cycle 2.
- busy_o=1 in CALC, FIX and DONE; busy_o=0 in IDLE.
- in_ready_o=0 outside IDLE; requests there are ignored, not queued.
- flush_i:
  - Takes priority over everything.
  - Any state goes to IDLE on the next edge; out_valid_o deasserts and results are discarded.
  - flush_i together with in_valid_i in IDLE: the request is not accepted.
- out_ready_i is ignored outside DONE. out_valid_o, once asserted, never drops without out_ready_i, flush_i or rst.
- A back-to-back request arriving in the cycle after the DONE handshake (IDLE) is accepted normally.
- Reset mid-CALC aborts immediately; no result is produced.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MUL..OP_REMU (4-bit, identical to ALUoperation 1000–1111);
  - state enum IDLE/CALC/FIX/DONE;
  - constants DIV0_QUOT=32'hFFFFFFFF and INT_MIN=32'h80000000.
- Sub-module muldiv_iter_core: the combinational single-step shift-add / restoring-subtract datapath (inputs: accumulator, operand, mode; outputs: next accumulator).
- The FSM, counter, sign handling and handshake stay in muldiv_sequencer.

Test Plan:
- mul a=7, b=-3 (32'hFFFFFFFD) -> after 34 cycles, result 32'hFFFFFFEB; mulh with the same operands -> 32'hFFFFFFFF; mulhu with the same operands -> 32'h00000006.
- div a=-20, b=6 -> result -3 (32'hFFFFFFFD); rem -> -2 (32'hFFFFFFFE); divu a=100, b=7 -> 14; remu -> 2.
- divu a=5, b=0 -> out_valid on cycle 2, result 32'hFFFFFFFF; rem a=5, b=0 -> 5; div a=32'h80000000, b=-1 -> 32'h80000000 with latency 2.
- Hold out_ready_i=0 for 10 cycles in DONE -> out_valid_o and result_o stable, busy_o=1, in_ready_o=0; a new in_valid_i is ignored; release -> IDLE, then the next request is accepted.
- Assert flush_i on CALC cycle 15 -> IDLE on the next cycle, out_valid_o never rises, a fresh mul 3*4 -> 12.
- Assert rst asynchronously mid-CALC -> all outputs at reset values before the next clock edge. An op_i=4'b0010 request -> illegal_o=1, result 0, latency 2.
